// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch front-end: opcodes, FSM states
// and the opcode legality helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  // Command word layout: {op, a, b}
  localparam int CMD_W = 36;

  typedef enum logic [2:0] {
    ST_SLEEP,
    ST_WAKE,
    ST_ACTIVE,
    ST_ISSUE,
    ST_WAIT,
    ST_ISO
  } dispatch_state_e;

  // Everything above DIV is unassigned and answered with an error response
  function automatic logic isLegalOp(input logic [3:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO. Push and pop may happen in the same cycle;
// requests against a full (push) or empty (pop) FIFO are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             doPush;
  logic             doPop;

  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rdPtr_q];

  // Occupancy follows the net effect of this cycle's push and pop
  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Command front-end and power sequencer for the multi-cycle ALU. Buffers
// commands, issues one at a time with stable operands, holds each response
// until consumed, and clamps/powers down the ALU after a stretch of idleness.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int IDLE_TIMEOUT  = 16,
  parameter int PWR_UP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        alu_pwr_en,
  output logic        iso_en,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_opcode,
  output logic        alu_start,
  input  logic        alu_busy,
  input  logic [15:0] alu_result,
  output logic        asleep
);

  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int WAKE_W = (PWR_UP_CYCLES > 1) ? $clog2(PWR_UP_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(PWR_UP_CYCLES - 1);

  dispatch_state_e   state_q;
  logic [IDLE_W-1:0] idleCnt_q;
  logic [WAKE_W-1:0] wakeCnt_q;
  logic              pwrEn_q;
  logic              isoEn_q;
  logic              asleep_q;
  logic              aluStart_q;
  logic [15:0]       aluA_q;
  logic [15:0]       aluB_q;
  logic [3:0]        aluOp_q;
  logic              rspValid_q;
  logic [15:0]       rspResult_q;
  logic              rspErr_q;

  logic              fifoFull;
  logic              fifoEmpty;
  logic [CMD_W-1:0]  fifoHead;
  logic [3:0]        headOp;
  logic [15:0]       headA;
  logic [15:0]       headB;
  logic              dispatch;

  assign headOp = fifoHead[35:32];
  assign headA  = fifoHead[31:16];
  assign headB  = fifoHead[15:0];

  // A held response blocks dispatch, which also keeps pop and response
  // consumption from landing in the same cycle
  assign dispatch = (state_q == ST_ACTIVE) && !fifoEmpty && !rspValid_q;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (dispatch),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign cmd_ready  = !fifoFull;
  assign rsp_valid  = rspValid_q;
  assign rsp_result = rspResult_q;
  assign rsp_err    = rspErr_q;
  assign alu_pwr_en = pwrEn_q;
  assign iso_en     = isoEn_q;
  assign alu_A      = aluA_q;
  assign alu_B      = aluB_q;
  assign alu_opcode = aluOp_q;
  assign alu_start  = aluStart_q;
  assign asleep     = asleep_q;

  // Sequencer: power is raised before the clamp drops and the clamp is raised before power drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SLEEP;
      idleCnt_q   <= '0;
      wakeCnt_q   <= '0;
      pwrEn_q     <= 1'b0;
      isoEn_q     <= 1'b1;
      asleep_q    <= 1'b1;
      aluStart_q  <= 1'b0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      rspValid_q  <= 1'b0;
      rspResult_q <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      idleCnt_q <= '0;
      if (rspValid_q && rsp_ready) begin
        rspValid_q <= 1'b0;
      end
      case (state_q)
        ST_SLEEP: begin
          if (!fifoEmpty) begin
            state_q   <= ST_WAKE;
            pwrEn_q   <= 1'b1;
            asleep_q  <= 1'b0;
            wakeCnt_q <= '0;
          end
        end
        ST_WAKE: begin
          if (wakeCnt_q == WAKE_LAST) begin
            state_q <= ST_ACTIVE;
            isoEn_q <= 1'b0;
          end else begin
            wakeCnt_q <= wakeCnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (dispatch) begin
            if (isLegalOp(headOp)) begin
              aluA_q     <= headA;
              aluB_q     <= headB;
              aluOp_q    <= headOp;
              aluStart_q <= 1'b1;
              state_q    <= ST_ISSUE;
            end else begin
              rspResult_q <= '0;
              rspErr_q    <= 1'b1;
              rspValid_q  <= 1'b1;
            end
          end else if (fifoEmpty && !rspValid_q) begin
            if (idleCnt_q == IDLE_LAST) begin
              state_q <= ST_ISO;
              isoEn_q <= 1'b1;
            end else begin
              idleCnt_q <= idleCnt_q + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          aluStart_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!alu_busy) begin
            rspResult_q <= alu_result;
            rspErr_q    <= 1'b0;
            rspValid_q  <= 1'b1;
            state_q     <= ST_ACTIVE;
          end
        end
        ST_ISO: begin
          pwrEn_q  <= 1'b0;
          asleep_q <= 1'b1;
          state_q  <= ST_SLEEP;
        end
        default: begin
          state_q    <= ST_SLEEP;
          pwrEn_q    <= 1'b0;
          isoEn_q    <= 1'b1;
          asleep_q   <= 1'b1;
          aluStart_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Command front-end and power sequencer placed directly upstream of the 16-bit multi-cycle ALU. It accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the ALU, holding operands stable for the ALU's full execution, and returns each result over a valid/ready response channel. When idle it clamps and powers down the ALU; on new work it powers the ALU up and releases the clamp.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- IDLE_TIMEOUT, 16, consecutive idle cycles in ACTIVE before power-down; ≥1
- PWR_UP_CYCLES, 4, cycles power is on with clamp held before release; ≥1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_a, cmd_b  in  16  operands
- cmd_op  in  4  opcode; 0000–0111 single-cycle, 1000 MUL, 1001 DIV, 1010–1111 illegal
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  consumer accepts
- rsp_result  out  16  ALU result; 0 on error
- rsp_err  out  1  illegal opcode
- alu_pwr_en  out  1  ALU power enable
- iso_en  out  1  ALU output clamp
- alu_A, alu_B  out  16  registered operands to ALU
- alu_opcode  out  4  registered opcode to ALU
- alu_start  out  1  one-cycle issue pulse
- alu_busy  in  1  ALU busy
- alu_result  in  16  ALU result
- asleep  out  1  high in SLEEP

## Operation
- Handshake: push on cmd_valid & cmd_ready. cmd_ready = !full and does not depend on power state. A push and a pop may occur in the same cycle. Response pops on rsp_valid & rsp_ready.
- FSM states: SLEEP, WAKE, ACTIVE, ISSUE, WAIT, ISO.
- SLEEP: alu_pwr_en=0, iso_en=1. FIFO non-empty → WAKE.
- WAKE: alu_pwr_en=1, iso_en=1. Counts PWR_UP_CYCLES cycles → ACTIVE with iso_en=0.
- ACTIVE: dispatch only when the FIFO is non-empty and rsp_valid=0. The FIFO head is popped.
  - Illegal opcode: load rsp_result=0, rsp_err=1, rsp_valid=1 at the edge; stay in ACTIVE.
  - Legal opcode: latch alu_A/B/opcode, set alu_start=1 → ISSUE.
- ISSUE: lasts exactly one cycle; alu_start=0 at its closing edge → WAIT.
- WAIT: on the first cycle with alu_busy=0, capture alu_result into rsp_result (rsp_err=0, rsp_valid=1) → ACTIVE. alu_A/B/opcode hold their values until the next issue.
- Idle counter: counts in ACTIVE while the FIFO is empty and rsp_valid=0; it clears otherwise. Reaching IDLE_TIMEOUT → ISO.
- ISO: iso_en=1, alu_pwr_en=1 for one cycle → SLEEP, where power drops. Clamp always precedes power-off, and power-on always precedes clamp release.
- A command arriving during ISO does not abort the power-down; it wakes the ALU from SLEEP.
- Reset, including mid-operation: state=SLEEP, FIFO empty, alu_pwr_en=0, iso_en=1, alu_start=0, alu_A/B/opcode=0, rsp_valid=0, rsp_result=0, rsp_err=0, asleep=1, idle counter=0. The in-flight command is lost.

## Timing
- The ALU samples alu_start at the edge closing ISSUE (edge k).
  - Single-cycle op: alu_busy=0 on the first WAIT cycle; capture at k+1.
  - MUL: alu_busy is high for 5 cycles; capture at k+6.
  - DIV: alu_busy is high for 9 cycles; capture at k+10.
- From an accept at edge e, while ACTIVE with an empty FIFO, rsp_valid rises after:
  - e+3 for ADD
  - e+8 for MUL
  - e+12 for DIV
  - e+1 for an illegal opcode
- Cold start from SLEEP adds 1 + PWR_UP_CYCLES cycles before ACTIVE.
- Throughput is one command in flight. The next dispatch requires the previous response to be consumed, and no dispatch occurs in the same cycle a response pops.

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD…OP_XNOR, OP_MUL=4'b1000, OP_DIV=4'b1001) and the dispatch FSM state enum.
- Sub-module alu_cmd_fifo: synchronous FIFO, 36-bit entries {op, a, b}, with full/empty flags and an async active-low reset.
- Top level holds the FSM, idle/wake counters, issue registers and the response register.

## Test plan
- Reset then idle: check alu_pwr_en=0, iso_en=1, asleep=1, cmd_ready=1, rsp_valid=0. Assert rst_n mid-DIV: all outputs return to reset values immediately.
- Cold ADD A=3, B=5: pwr_en rises first; iso_en falls PWR_UP_CYCLES later; one alu_start pulse; rsp_result=8, rsp_err=0.
- Warm MUL A=300, B=200: alu_A/B stay stable through busy; rsp_valid comes 8 cycles after accept with rsp_result=16'hEA60. DIV 100/7 → 14 at 12 cycles. DIV 5/0 → 0.
- Queue of 5 commands with rsp_ready=0: cmd_ready drops after 4 are accepted. Only one response is held and no further alu_start occurs until rsp_ready=1. Order is preserved.
- cmd_op=4'b1100: no alu_start; rsp_err=1, rsp_result=0 one cycle after accept.
- IDLE_TIMEOUT cycles with no work: iso_en is already 1 when alu_pwr_en falls. A command pushed during ISO completes power-down, then wakes and returns the correct result.
